serial_feeder: RTL and testbench

Parallel-to-serial front end that produces the single-bit stream `x` consumed by the downstream serial pattern detector. It accepts WIDTH-bit words over a valid/ready handshake into a one-word holding register. It then shifts each word out one bit per clock. Back-to-back words stream with no idle gap. When no data is pending, the line sits at a defined idle level so the detector sees a clean, non-matching input.

---
 rtl/serial_feeder.sv | 148 ++++++++++++++
 tb/tb_serial_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_feeder.sv
// -----------------------------------------------------------------------------
// serial_feeder
//
// Parallel-to-serial front end for the serial pattern detector. WIDTH-bit
// words arrive over a valid/ready handshake into a one-word holding register
// and are shifted out one bit per clock on x. A word waiting in the holding
// register is loaded on the same edge that ends the previous word, so
// consecutive words leave with no idle gap. With nothing to send, x rests at
// IDLE_BIT and x_valid is low.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//   IDLE_BIT   level driven on x while no word is being shifted
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   din        parallel word to serialize
//   din_valid  din holds a word for transfer
//   din_ready  a word can be accepted this cycle (registers and rst only)
//   x          serial bit, registered
//   x_valid    x carries a data bit, registered
//   word_done  one-cycle pulse while the last bit of a word is on x
//   busy       shifting, or the holding register is occupied
// -----------------------------------------------------------------------------
module serial_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Bit of a word that appears on the line first.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the output position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_t             state_q,     state_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   hold_reg_q,  hold_reg_d;
  logic [WIDTH-1:0]   shift_q,     shift_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               x_q,         x_d;
  logic               x_valid_q,   x_valid_d;
  logic               word_done_q, word_done_d;

  logic accept;
  logic load;

  // Ready depends only on registered state and rst, never on din_valid.
  assign din_ready = !hold_full_q && !rst;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_reg_d  = hold_reg_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          // Chain straight into the pending word, else drop back to idle.
          if (hold_full_q) load = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          shift_d = advance(shift_q);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_reg_q;
      cnt_d       = '0;
      state_d     = S_SHIFT;
      hold_full_d = 1'b0;
    end

    // accept needs an empty holding register and load needs a full one,
    // so the two never collide on hold_full.
    if (accept) begin
      hold_reg_d  = din;
      hold_full_d = 1'b1;
    end

    // Line outputs are registered from the next-state view.
    x_valid_d   = (state_d == S_SHIFT);
    x_d         = (state_d == S_SHIFT) ? out_bit(shift_d) : IDLE_BIT;
    word_done_d = (state_d == S_SHIFT) && (cnt_d == LAST_IDX);
  end

  // ---- stage boundary: control and line outputs (reset), data words (no reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
    end
    hold_reg_q <= hold_reg_d;
    shift_q    <= shift_d;
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q == S_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_feeder
//
// Two instances: u0 (WIDTH=8, MSB first, idle 0) and u1 (WIDTH=4, LSB first,
// idle 1). Each accepted word is turned into a timed schedule of expected
// line bits: the first bit goes out two cycles after the accept cycle, or
// right after the previous word ends, whichever is later. A monitor compares
// the line, din_ready and busy against that schedule every cycle.
// -----------------------------------------------------------------------------
module tb_serial_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din0;
  logic [3:0] din1;
  logic [1:0] dv, rdy, xo, xv, wd, bz;

  serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv[0]), .din_ready(rdy[0]),
    .x(xo[0]), .x_valid(xv[0]), .word_done(wd[0]), .busy(bz[0])
  );

  serial_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv[1]), .din_ready(rdy[1]),
    .x(xo[1]), .x_valid(xv[1]), .word_done(wd[1]), .busy(bz[1])
  );

  typedef struct {
    int   cyc;
    logic b;
    logic done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_end[2]  = '{-1, -1};
  int last_acc[2]  = '{-10, -10};
  int hold_free[2] = '{0, 0};
  int n_acc[2]     = '{0, 0};
  int n_sent[2]    = '{0, 0};

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic logic idle_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Schedule the bits of an accepted word on the line.
  task automatic push_word(input int i, input int k, input logic [7:0] w);
    int s;
    int wd_n;
    exp_t e;
    wd_n = w_of(i);
    s = k + 2;
    if (last_end[i] + 1 > s) s = last_end[i] + 1;
    for (int j = 0; j < wd_n; j++) begin
      e.cyc  = s + j;
      e.b    = (i == 0) ? w[wd_n-1-j] : w[j];
      e.done = (j == wd_n - 1);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    last_end[i]  = s + wd_n - 1;
    hold_free[i] = s;
    last_acc[i]  = k;
    n_acc[i]++;
  endtask

  // Reset in cycle k: nothing scheduled after k ever appears.
  task automatic purge(input int i, input int k);
    if (i == 0) begin
      while (q0.size() > 0 && q0[q0.size()-1].cyc > k) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[q1.size()-1].cyc > k) void'(q1.pop_back());
    end
    last_end[i]  = k;
    last_acc[i]  = k;
    hold_free[i] = 0;
  endtask

  task automatic check_inst(input int i);
    exp_t e;
    bit   have;
    logic [2:0] got, want;
    logic rdy_exp, busy_exp;
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    got  = {xv[i], xo[i], wd[i]};
    want = have ? {1'b1, e.b, e.done} : {1'b0, idle_of(i), 1'b0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL line u%0d cyc=%0d got x_valid/x/word_done=%b required=%b", i, cyc, got, want);
    end
    rdy_exp = !rst && (cyc >= hold_free[i]);
    checks++;
    if (rdy[i] !== rdy_exp) begin
      errors++;
      $display("FAIL din_ready u%0d cyc=%0d got=%b required=%b", i, cyc, rdy[i], rdy_exp);
    end
    busy_exp = (cyc > last_acc[i]) && (cyc <= last_end[i]);
    checks++;
    if (bz[i] !== busy_exp) begin
      errors++;
      $display("FAIL busy u%0d cyc=%0d got=%b required=%b", i, cyc, bz[i], busy_exp);
    end
  endtask

  // Monitor: compare this cycle, then fold in what the coming edge does.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check_inst(i);
      if (rst) purge(i, cyc);
      else if (dv[i] && rdy[i]) push_word(i, cyc, (i == 0) ? din0 : {4'b0, din1});
    end
  end

  // Called just after a rising edge; returns just after the edge that took it.
  task automatic send(input int i, input logic [7:0] w, input bit keep);
    bit accepted;
    accepted = 1'b0;
    dv[i] = 1'b1;
    if (i == 0) din0 = w;
    else        din1 = w[3:0];
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (rdy[i]) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout u%0d word=%h got=no_ready required=ready", i, w);
    end else begin
      n_sent[i]++;
    end
    if (!keep) dv[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst  = 1'b1;
    dv   = 2'b00;
    din0 = 8'h00;
    din1 = 4'h0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single words on each instance.
    send(0, 8'hA5, 1'b0); idle(12);
    send(1, 8'h01, 1'b0); idle(8);

    // Back-to-back with valid held high.
    send(0, 8'h05, 1'b1); send(0, 8'h80, 1'b0); idle(20);

    // Three words offered continuously.
    send(0, 8'h11, 1'b1); send(0, 8'h22, 1'b1); send(0, 8'h33, 1'b0); idle(30);

    // Detector-facing words.
    send(0, 8'h28, 1'b1); send(0, 8'h00, 1'b0); idle(20);

    // Reset mid-word with a second word waiting in the holding register.
    send(0, 8'hFF, 1'b1); send(0, 8'h55, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(0, 8'h81, 1'b0); idle(15);
    send(1, 8'h0E, 1'b1); send(1, 8'h07, 1'b0); idle(10);

    // Randomized traffic on both instances at once.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int g;
          g = $urandom_range(0, 3);
          send(0, 8'($urandom), g == 0);
          if (g != 0) idle(g);
        end
        dv[0] = 1'b0;
      end
      begin
        for (int m = 0; m < 40; m++) begin
          int h;
          h = $urandom_range(0, 3);
          send(1, 8'($urandom), h == 0);
          if (h != 0) idle(h);
        end
        dv[1] = 1'b0;
      end
    join
    idle(40);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending bits required=0/0", q0.size(), q1.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (n_acc[i] != n_sent[i]) begin
        errors++;
        $display("FAIL transfers u%0d got=%0d required=%0d", i, n_acc[i], n_sent[i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
